// File: rtl/screen_fill_arbiter_if.sv
// Screen-region bus bundle shared by the CPU, the fill controller and the screen RAM port.
// Optional SCREEN_FILL_RANGE_EN adds the fill_first/fill_last range inputs.
interface screen_fill_arbiter_if;
    logic        cpu_sel;
    logic        cpu_load;
    logic [12:0] cpu_address;
    logic [15:0] cpu_in;
    logic [15:0] cpu_out;
    logic        cpu_wait;
    logic        fill_start;
    logic        fill_abort;
    logic [15:0] fill_pattern;
    logic        fill_busy;
    logic        fill_done;
    logic        scr_load;
    logic [12:0] scr_address;
    logic [15:0] scr_in;
    logic [15:0] scr_out;
`ifdef SCREEN_FILL_RANGE_EN
    logic [12:0] fill_first;
    logic [12:0] fill_last;
`endif

    modport master (
`ifdef SCREEN_FILL_RANGE_EN
        output fill_first,
        output fill_last,
`endif
        output cpu_sel, output cpu_load, output cpu_address, output cpu_in,
        input  cpu_out, input  cpu_wait,
        output fill_start, output fill_abort, output fill_pattern,
        input  fill_busy, input  fill_done,
        input  scr_load, input  scr_address, input  scr_in,
        output scr_out
    );

    modport slave (
`ifdef SCREEN_FILL_RANGE_EN
        input  fill_first,
        input  fill_last,
`endif
        input  cpu_sel, input  cpu_load, input  cpu_address, input  cpu_in,
        output cpu_out, output cpu_wait,
        input  fill_start, input  fill_abort, input  fill_pattern,
        output fill_busy, output fill_done,
        output scr_load, output scr_address, output scr_in,
        input  scr_out
    );
endinterface

// File: rtl/screen_fill_arbiter.sv
// Shares the single screen RAM port between the CPU and a pattern-fill engine.
// Define SCREEN_FILL_RANGE_EN to fill a sub-range (fill_first..fill_last) instead of the whole screen.
module screen_fill_arbiter #(
    parameter int CPU_SLOT  = 4,
    parameter int LAST_WORD = 8191
) (
    input  logic                 clk,
    input  logic                 reset,
    screen_fill_arbiter_if.slave bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

    localparam logic [3:0]  SLOT_LAST = 4'(CPU_SLOT - 1);
    localparam logic [12:0] LAST_ADDR = 13'(LAST_WORD);

    state_t      state_r;
    logic [12:0] ptr_r;
    logic [12:0] end_r;
    logic [3:0]  slot_r;
    logic [15:0] pattern_r;
    logic        busy_r;
    logic        done_r;

    logic        cpu_grant_s;
    logic        fill_own_s;
    logic [12:0] first_s;
    logic [12:0] last_s;

`ifdef SCREEN_FILL_RANGE_EN
    assign first_s = bus.fill_first;
    assign last_s  = bus.fill_last;
`else
    assign first_s = 13'd0;
    assign last_s  = LAST_ADDR;
`endif

    // Port ownership: CPU owns in IDLE, and in FILL only on its reserved slot when it asks.
    always_comb begin
        cpu_grant_s = 1'b1;
        fill_own_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cpu_grant_s = 1'b1;
                fill_own_s  = 1'b0;
            end
            FILL: begin
                cpu_grant_s = bus.cpu_sel && (slot_r == SLOT_LAST);
                fill_own_s  = !cpu_grant_s;
            end
            default: begin
                cpu_grant_s = 1'b1;
                fill_own_s  = 1'b0;
            end
        endcase
    end

    // Screen port mux: fill engine when it owns the port, otherwise CPU passthrough.
    always_comb begin
        bus.scr_load    = 1'b0;
        bus.scr_address = 13'd0;
        bus.scr_in      = 16'd0;
        if (fill_own_s) begin
            bus.scr_load    = 1'b1;
            bus.scr_address = ptr_r;
            bus.scr_in      = pattern_r;
        end else begin
            bus.scr_load    = bus.cpu_sel & bus.cpu_load;
            bus.scr_address = bus.cpu_address;
            bus.scr_in      = bus.cpu_in;
        end
    end

    assign bus.cpu_wait  = bus.cpu_sel & ~cpu_grant_s;
    assign bus.cpu_out   = bus.scr_out;
    assign bus.fill_busy = busy_r;
    assign bus.fill_done = done_r;

    // Fill FSM; abort beats start in both states, and the pointer stops at the last address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            ptr_r     <= 13'd0;
            end_r     <= 13'd0;
            slot_r    <= 4'd0;
            pattern_r <= 16'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.fill_abort) begin
                        state_r <= IDLE;
                    end else if (bus.fill_start) begin
                        pattern_r <= bus.fill_pattern;
                        ptr_r     <= first_s;
                        end_r     <= last_s;
                        slot_r    <= 4'd0;
                        if (first_s > last_s) begin
                            done_r <= 1'b1;
                        end else begin
                            state_r <= FILL;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FILL: begin
                    slot_r <= (slot_r == SLOT_LAST) ? 4'd0 : slot_r + 4'd1;
                    if (bus.fill_abort) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (fill_own_s) begin
                        if (ptr_r == end_r) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            ptr_r <= ptr_r + 13'd1;
                        end
                    end else begin
                        state_r <= FILL;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
